uart_rx_ctrl: RTL and testbench

UART receive controller that sequences the oversampling baud-tick generator and turns the serial `rx` line into bytes. It synchronises `rx`, detects the start edge, restarts the tick generator on that edge, samples mid-bit (8N1, LSB first), checks the stop bit and delivers bytes over a valid/ready handshake. It sits between the board pin and the byte-level consumer (command parser / FIFO), replacing free-running tick use with edge-aligned sampling.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rx_tick_gen.sv | 33 +++
 rtl/uart_rx_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, default oversampling
// and clock-per-tick values, and the line levels of the framing bits.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int UART_OVERSAMPLE        = 16;
    localparam int UART_DEF_CLKS_PER_TICK = 326;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_tick_gen.sv
// Restartable oversample tick generator: one-cycle tick every CLKS_PER_TICK
// clocks, phase-aligned to the most recent restart pulse.
module rx_tick_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = UART_DEF_CLKS_PER_TICK
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt;

    // Restart zeroes the phase so the first tick lands CLKS_PER_TICK clocks later.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchronises rx, aligns the tick generator to the start edge,
// samples mid-bit (LSB first), checks the stop bit and hands bytes out via valid/ready.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = UART_DEF_CLKS_PER_TICK,
    parameter int OVERSAMPLE    = UART_OVERSAMPLE,
    parameter int DATA_BITS     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

    rx_state_t     state;
    logic          sync1, sync2, sync3;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg, shreg_next;
    logic          tick, restart, fall;

    assign fall    = sync3 & ~sync2;
    assign restart = (state == IDLE) && fall;
    assign busy    = (state != IDLE);

    rx_tick_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    // New bits enter at the top of the frame width so the first bit ends at bit 0.
    always_comb begin
        shreg_next = shreg >> 1;
        shreg_next[DATA_BITS-1] = sync2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {sync1, sync2, sync3} <= 3'b111;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        shreg    <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            state    <= (sync2 == START_BIT) ? DATA : IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= shreg_next;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) state <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // A completed byte never overwrites one the consumer has not taken.
                    if (tick) begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (sync2 == STOP_BIT) begin
                                if (!valid || ready) begin
                                    data  <= shreg;
                                    valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 4 clocks/tick, 16 ticks/bit (64 clocks/bit).
module tb_uart_rx_ctrl;

    localparam int CPT      = 4;
    localparam int OS       = 16;
    localparam int BIT_CLKS = CPT * OS;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, busy, frame_err, overrun;

    int checks = 0;
    int fails  = 0;

    int         acc_cnt      = 0;
    int         ferr_cnt     = 0;
    int         ovr_cnt      = 0;
    int         busy_cycles  = 0;
    int         vr_busy_err  = 0;
    logic       prev_valid   = 1'b0;
    logic [7:0] acc_log [4];

    uart_rx_ctrl #(
        .CLKS_PER_TICK(CPT),
        .OVERSAMPLE   (OS),
        .DATA_BITS    (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid && ready) begin
            if (acc_cnt < 4) acc_log[acc_cnt] = data;
            acc_cnt++;
        end
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (busy) busy_cycles++;
        if (valid && !prev_valid && busy) vr_busy_err++;
        prev_valid = valid;
    end

    task automatic waitClocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearCounters();
        acc_cnt     = 0;
        ferr_cnt    = 0;
        ovr_cnt     = 0;
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) acc_log[i] = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one full 8N1 frame; rx is left at the stop-bit level.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        waitClocks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            waitClocks(BIT_CLKS);
        end
        rx = stop_bit;
        waitClocks(BIT_CLKS);
    endtask

    initial begin
        waitClocks(5);
        checkOutput("reset_data", 32'(data), 32'h00);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        waitClocks(10);

        $display("[TB] frame 0xA5");
        clearCounters();
        applyStimulus(8'hA5, 1'b1);
        checkOutput("a5_count", 32'(acc_cnt), 32'd1);
        checkOutput("a5_data", 32'(acc_log[0]), 32'hA5);
        checkOutput("a5_ferr", 32'(ferr_cnt), 32'd0);
        checkOutput("a5_ovr", 32'(ovr_cnt), 32'd0);
        checkOutput("a5_busy_idle", 32'(busy), 32'h0);
        checkOutput("a5_busy_len", 32'(busy_cycles >= 600 && busy_cycles <= 620), 32'h1);

        $display("[TB] false start");
        clearCounters();
        rx = 1'b0;
        waitClocks(20);
        rx = 1'b1;
        waitClocks(60);
        checkOutput("fs_count", 32'(acc_cnt), 32'd0);
        checkOutput("fs_busy", 32'(busy), 32'h0);
        checkOutput("fs_busy_len", 32'(busy_cycles >= 30 && busy_cycles <= 40), 32'h1);
        checkOutput("fs_ferr", 32'(ferr_cnt), 32'd0);

        $display("[TB] frame 0x3C with bad stop bit, then 0x55");
        clearCounters();
        applyStimulus(8'h3C, 1'b0);
        checkOutput("3c_ferr_pulse", 32'(ferr_cnt), 32'd1);
        checkOutput("3c_count", 32'(acc_cnt), 32'd0);
        checkOutput("3c_valid", 32'(valid), 32'h0);
        rx = 1'b1;
        waitClocks(20);
        clearCounters();
        applyStimulus(8'h55, 1'b1);
        checkOutput("55_count", 32'(acc_cnt), 32'd1);
        checkOutput("55_data", 32'(acc_log[0]), 32'h55);
        checkOutput("55_ferr", 32'(ferr_cnt), 32'd0);

        $display("[TB] overrun with ready low");
        ready = 1'b0;
        clearCounters();
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        checkOutput("ovr_valid", 32'(valid), 32'h1);
        checkOutput("ovr_data_held", 32'(data), 32'h11);
        checkOutput("ovr_pulse", 32'(ovr_cnt), 32'd1);
        checkOutput("ovr_none_taken", 32'(acc_cnt), 32'd0);
        ready = 1'b1;
        waitClocks(1);
        checkOutput("ovr_valid_drop", 32'(valid), 32'h0);
        checkOutput("ovr_taken", 32'(acc_cnt), 32'd1);
        checkOutput("ovr_taken_data", 32'(acc_log[0]), 32'h11);
        checkOutput("ovr_data_kept", 32'(data), 32'h11);

        $display("[TB] reset mid-frame");
        clearCounters();
        rx = 1'b0;
        waitClocks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            waitClocks(BIT_CLKS);
        end
        checkOutput("mid_busy", 32'(busy), 32'h1);
        rx    = 1'b1;
        reset = 1'b1;
        waitClocks(1);
        checkOutput("mid_rst_data", 32'(data), 32'h00);
        checkOutput("mid_rst_valid", 32'(valid), 32'h0);
        checkOutput("mid_rst_busy", 32'(busy), 32'h0);
        checkOutput("mid_rst_ferr", 32'(frame_err), 32'h0);
        checkOutput("mid_rst_ovr", 32'(overrun), 32'h0);
        reset = 1'b0;
        waitClocks(20);
        clearCounters();
        applyStimulus(8'h0F, 1'b1);
        checkOutput("0f_count", 32'(acc_cnt), 32'd1);
        checkOutput("0f_data", 32'(acc_log[0]), 32'h0F);
        checkOutput("0f_ferr", 32'(ferr_cnt), 32'd0);

        $display("[TB] back-to-back 0x00, 0xFF");
        clearCounters();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        checkOutput("b2b_count", 32'(acc_cnt), 32'd2);
        checkOutput("b2b_first", 32'(acc_log[0]), 32'h00);
        checkOutput("b2b_second", 32'(acc_log[1]), 32'hFF);
        checkOutput("b2b_ferr", 32'(ferr_cnt), 32'd0);
        checkOutput("b2b_ovr", 32'(ovr_cnt), 32'd0);

        checkOutput("valid_rise_busy_low", 32'(vr_busy_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
